// File: rtl/thermo_spi_responder.sv
// thermo_spi_responder: SPI device that emulates a MAX31855-style thermocouple converter.
// A 32-bit frame is built from the parallel temperature and fault inputs on `load`. It becomes
// readable after a modelled conversion time and is shifted out MSB first on MISO.
//
// Frame layout: [31:18] tc_temp, [17] 0, [16] |fault_in, [15:4] junction_temp, [3] 0,
//               [2:0] fault_in {SCV, SCG, OC}.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth for sclk and cs_n (minimum 2)
//   CONV_CYCLES  clk cycles from a load until the new frame becomes readable
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   sclk, cs_n        SPI clock (CPOL=0) and active-low select, asynchronous to clk
//   miso              serial data; changes on synchronized sclk/cs_n falling edges
//   tc_temp           14-bit signed thermocouple temperature
//   junction_temp     12-bit signed junction temperature
//   fault_in          fault flags
//   load              one-cycle strobe that captures the inputs into the staging frame
//   conv_busy         high while a conversion is pending
//   frame_done        one-cycle pulse after the 32nd bit has been shifted out
//
// Build option: define THERMO_SPI_RESP_TRISTATE_EN to drive miso as 1'bz while idle.
// Without it, miso is driven 0 while idle.

module thermo_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CONV_CYCLES = 800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  output logic        miso,
  input  logic [13:0] tc_temp,
  input  logic [11:0] junction_temp,
  input  logic [2:0]  fault_in,
  input  logic        load,
  output logic        conv_busy,
  output logic        frame_done
);

  localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StTail} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, sclk_fall, cs_fall, cs_rise;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        frame_done_q, frame_done_d;

  logic [31:0]     staging_q, staging_d;
  logic [31:0]     result_q, result_d;
  logic [CntW-1:0] conv_cnt_q, conv_cnt_d;
  logic            conv_busy_q, conv_busy_d;
  logic [31:0]     frame_in;

  assign frame_in = {tc_temp, 1'b0, |fault_in, junction_temp, 1'b0, fault_in};

  // Synchronizers and edge detection on the last synchronized stage.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  // Conversion model. On expiry with cs_n low, the counter parks at its last value and
  // conv_busy stays high. The result update is then applied in the first cycle that sees
  // cs_n high again.
  always_comb begin
    staging_d   = staging_q;
    result_d    = result_q;
    conv_cnt_d  = conv_cnt_q;
    conv_busy_d = conv_busy_q;
    if (load) begin
      staging_d   = frame_in;
      conv_cnt_d  = '0;
      conv_busy_d = 1'b1;
    end else if (conv_busy_q) begin
      if (conv_cnt_q == CntLast) begin
        if (cs_s) begin
          result_d    = staging_q;
          conv_busy_d = 1'b0;
        end
      end else begin
        conv_cnt_d = conv_cnt_q + CntW'(1);
      end
    end
  end

  // Serializer. miso is the MSB of the shift register. Zeros are shifted in, so the register
  // is already empty once the frame has gone out, and tail bits read as 0.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    if (cs_rise) begin
      state_d = StIdle;
      shift_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StShift;
            shift_d   = result_q;
            bit_cnt_d = 5'd31;
          end
        end
        StShift: begin
          if (sclk_fall) begin
            shift_d = {shift_q[30:0], 1'b0};
            if (bit_cnt_q == 5'd0) begin
              state_d      = StTail;
              frame_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - 5'd1;
            end
          end
        end
        StTail: begin
          shift_d = '0;
        end
        default: begin
          state_d = StIdle;
          shift_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      staging_q    <= '0;
      result_q     <= '0;
      conv_cnt_q   <= '0;
      conv_busy_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      staging_q    <= staging_d;
      result_q     <= result_d;
      conv_cnt_q   <= conv_cnt_d;
      conv_busy_q  <= conv_busy_d;
    end
  end

`ifdef THERMO_SPI_RESP_TRISTATE_EN
  assign miso = (state_q == StIdle) ? 1'bz : shift_q[31];
`else
  assign miso = shift_q[31];
`endif

  assign conv_busy  = conv_busy_q;
  assign frame_done = frame_done_q;

endmodule
